// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader. Receives a framed byte stream and writes it
// word by word into the CPU instruction memory, keeping the CPU in reset
// until a complete image with a matching checksum has been written.
//
// Frame: LEN byte L (word count), 4*L data bytes (little-endian per word),
// then one CHK byte equal to the XOR of L and every data byte.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      one-cycle pulse starting a load (honoured in IDLE/DONE/ERR)
//   i_rx_valid   i_rx_data holds a byte
//   i_rx_data    received byte
//   o_rx_ready   loader accepts a byte (transfer on valid & ready at an edge)
//   o_mem_we     instruction memory write strobe, one cycle per word
//   o_mem_addr   instruction memory word address
//   o_mem_wdata  instruction memory word data
//   o_cpu_rst_n  CPU reset, active-low; released only after a good load
//   o_done       high while a good image is loaded
//   o_error      high after a length or checksum error
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int WIDTH    = 32,
    parameter int MEM_SIZE = 5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_rx_valid,
    input  logic [7:0]          i_rx_data,
    output logic                o_rx_ready,
    output logic                o_mem_we,
    output logic [MEM_SIZE-1:0] o_mem_addr,
    output logic [WIDTH-1:0]    o_mem_wdata,
    output logic                o_cpu_rst_n,
    output logic                o_done,
    output logic                o_error
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // Registers
    state_t                r_state;
    logic [1:0]            r_byte_cnt;
    logic [MEM_SIZE:0]     r_word_cnt;
    logic [MEM_SIZE:0]     r_len;
    logic [7:0]            r_chk;
    logic [WIDTH-1:0]      r_asm;
    logic                  r_rx_ready;
    logic                  r_mem_we;
    logic [MEM_SIZE-1:0]   r_mem_addr;
    logic [WIDTH-1:0]      r_mem_wdata;
    logic                  r_cpu_rst_n;
    logic                  r_done;
    logic                  r_error;

    // Next-state values
    state_t                w_state_nxt;
    logic [1:0]            w_byte_cnt_nxt;
    logic [MEM_SIZE:0]     w_word_cnt_nxt;
    logic [MEM_SIZE:0]     w_len_nxt;
    logic [7:0]            w_chk_nxt;
    logic [WIDTH-1:0]      w_asm_nxt;
    logic                  w_rx_ready_nxt;
    logic                  w_mem_we_nxt;
    logic [MEM_SIZE-1:0]   w_mem_addr_nxt;
    logic [WIDTH-1:0]      w_mem_wdata_nxt;
    logic                  w_cpu_rst_n_nxt;
    logic                  w_done_nxt;
    logic                  w_error_nxt;

    // Helpers
    logic                  w_accept;
    logic                  w_len_bad;
    logic [MEM_SIZE:0]     w_word_cnt_inc;
    logic [WIDTH-1:0]      w_lane;

    assign w_accept       = i_rx_valid & r_rx_ready;
    // L above the memory depth cannot be stored; compare in 32 bits so the
    // full 8-bit length range is checked without truncation.
    assign w_len_bad      = (i_rx_data == 8'd0) ||
                            ({24'd0, i_rx_data} > (32'd1 << MEM_SIZE));
    assign w_word_cnt_inc = r_word_cnt + {{MEM_SIZE{1'b0}}, 1'b1};

    // Assembly word with the current byte inserted at lane r_byte_cnt.
    always_comb begin
        w_lane = r_asm;
        w_lane[{r_byte_cnt, 3'b000} +: 8] = i_rx_data;
    end

    // Next-state and next-register computation for the load sequence.
    always_comb begin
        w_state_nxt     = r_state;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_word_cnt_nxt  = r_word_cnt;
        w_len_nxt       = r_len;
        w_chk_nxt       = r_chk;
        w_asm_nxt       = r_asm;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;

        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    w_state_nxt    = S_LEN;
                    w_byte_cnt_nxt = 2'd0;
                    w_word_cnt_nxt = '0;
                    w_chk_nxt      = 8'd0;
                    w_asm_nxt      = '0;
                    w_mem_addr_nxt = '0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_LEN: begin
                if (w_accept) begin
                    if (w_len_bad) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_len_nxt   = i_rx_data[MEM_SIZE:0];
                        w_chk_nxt   = i_rx_data;
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_state_nxt = S_LEN;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_asm_nxt      = w_lane;
                    w_chk_nxt      = r_chk ^ i_rx_data;
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    // Fourth byte completes the word: write it next cycle.
                    if (r_byte_cnt == 2'd3) begin
                        w_mem_we_nxt    = 1'b1;
                        w_mem_wdata_nxt = w_lane;
                        w_mem_addr_nxt  = r_word_cnt[MEM_SIZE-1:0];
                        w_word_cnt_nxt  = w_word_cnt_inc;
                        if (w_word_cnt_inc == r_len) begin
                            w_state_nxt = S_CHK;
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_CHK: begin
                if (w_accept) begin
                    if (i_rx_data == r_chk) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end else begin
                    w_state_nxt = S_CHK;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so outputs are registered alongside it.
    always_comb begin
        w_rx_ready_nxt  = 1'b0;
        w_cpu_rst_n_nxt = 1'b0;
        w_done_nxt      = 1'b0;
        w_error_nxt     = 1'b0;
        case (w_state_nxt)
            S_LEN, S_DATA, S_CHK: w_rx_ready_nxt = 1'b1;
            S_DONE: begin
                w_done_nxt      = 1'b1;
                w_cpu_rst_n_nxt = 1'b1;
            end
            S_ERR:   w_error_nxt = 1'b1;
            default: w_rx_ready_nxt = 1'b0;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= 2'd0;
            r_word_cnt  <= '0;
            r_len       <= '0;
            r_chk       <= 8'd0;
            r_asm       <= '0;
            r_rx_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_len       <= w_len_nxt;
            r_chk       <= w_chk_nxt;
            r_asm       <= w_asm_nxt;
            r_rx_ready  <= w_rx_ready_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_cpu_rst_n <= w_cpu_rst_n_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
        end
    end

    assign o_rx_ready  = r_rx_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_cpu_rst_n = r_cpu_rst_n;
    assign o_done      = r_done;
    assign o_error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed self-checking bench for imem_loader. Expected memory writes are
// queued as frames are sent and popped whenever the loader strobes mem_we.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'd0;
    logic        rx_ready;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        error;

    int          checks   = 0;
    int          failures = 0;
    int          wr_count = 0;
    logic [36:0] exp_q [$];
    logic [31:0] prog [0:31];

    imem_loader #(.WIDTH(32), .MEM_SIZE(5)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .o_rx_ready  (rx_ready),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_cpu_rst_n (cpu_rst_n),
        .o_done      (done),
        .o_error     (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard on every write strobe.
    task automatic mon();
        logic [36:0] e;
        if (mem_we === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {63'd0, mem_we}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {59'd0, mem_addr}, {59'd0, e[36:32]});
                chk("wr_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        chk("rx_ready_before_byte", {63'd0, rx_ready}, 64'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    // Send a frame of n words from prog[]; chk_xor corrupts the CHK byte,
    // spur pulses start alongside a DATA byte.
    task automatic send_frame(input int n, input bit gaps, input logic [7:0] chk_xor, input bit spur);
        logic [7:0] c;
        logic [7:0] b;
        c = n[7:0];
        send_byte(n[7:0], gaps);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = prog[i][8*k +: 8];
                c = c ^ b;
                if (k == 3) exp_q.push_back({i[4:0], prog[i]});
                if (spur && i == 0 && k == 2) start = 1'b1;
                send_byte(b, gaps);
                start = 1'b0;
            end
        end
        send_byte(c ^ chk_xor, gaps);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"},  {63'd0, rx_ready},  64'd0);
        chk({tag, "_mem_we"},    {63'd0, mem_we},    64'd0);
        chk({tag, "_mem_addr"},  {59'd0, mem_addr},  64'd0);
        chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
        chk({tag, "_cpu_rst_n"}, {63'd0, cpu_rst_n}, 64'd0);
        chk({tag, "_done"},      {63'd0, done},      64'd0);
        chk({tag, "_error"},     {63'd0, error},     64'd0);
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"},      {63'd0, done},      64'd1);
        chk({tag, "_cpu_rst_n"}, {63'd0, cpu_rst_n}, 64'd1);
        chk({tag, "_error"},     {63'd0, error},     64'd0);
        chk({tag, "_rx_ready"},  {63'd0, rx_ready},  64'd0);
        chk({tag, "_q_empty"},   exp_q.size(),       64'd0);
    endtask

    task automatic check_err(input string tag);
        chk({tag, "_error"},     {63'd0, error},     64'd1);
        chk({tag, "_done"},      {63'd0, done},      64'd0);
        chk({tag, "_cpu_rst_n"}, {63'd0, cpu_rst_n}, 64'd0);
        chk({tag, "_rx_ready"},  {63'd0, rx_ready},  64'd0);
    endtask

    initial begin
        int wr0;

        // Reset state
        #1;
        check_reset_vals("reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_reset_vals("idle");

        // rx_valid in IDLE must not be consumed
        rx_valid = 1'b1;
        rx_data  = 8'h02;
        repeat (3) begin
            tick();
            chk("idle_rx_ready", {63'd0, rx_ready}, 64'd0);
        end
        rx_valid = 1'b0;

        // Good load, back-to-back
        prog[0] = 32'h00500093;
        prog[1] = 32'h00108113;
        pulse_start();
        chk("start_rx_ready", {63'd0, rx_ready}, 64'd1);
        chk("start_cpu_held", {63'd0, cpu_rst_n}, 64'd0);
        wr0 = wr_count;
        send_frame(2, 1'b0, 8'h00, 1'b0);
        check_done("good");
        chk("good_wr_count", wr_count - wr0, 64'd2);

        // rx_valid in DONE is ignored
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) begin
            tick();
            chk("done_hold_rx_ready", {63'd0, rx_ready}, 64'd0);
            chk("done_hold_done", {63'd0, done}, 64'd1);
        end
        rx_valid = 1'b0;

        // Restart from DONE, then bad checksum (0x44)
        pulse_start();
        chk("restart_done", {63'd0, done}, 64'd0);
        chk("restart_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd0);
        chk("restart_rx_ready", {63'd0, rx_ready}, 64'd1);
        wr0 = wr_count;
        send_frame(2, 1'b0, 8'h07, 1'b0);
        check_err("badchk");
        chk("badchk_wr_count", wr_count - wr0, 64'd2);
        chk("badchk_q_empty", exp_q.size(), 64'd0);

        // Restart from ERR with the good frame
        pulse_start();
        chk("restart_err_error", {63'd0, error}, 64'd0);
        send_frame(2, 1'b0, 8'h00, 1'b0);
        check_done("reload");

        // Length 0 -> ERR, no writes
        pulse_start();
        wr0 = wr_count;
        send_byte(8'h00, 1'b0);
        check_err("len0");
        tick();
        chk("len0_no_write", wr_count - wr0, 64'd0);

        // Length 33 -> ERR
        pulse_start();
        send_byte(8'h21, 1'b0);
        check_err("len33");
        tick();
        chk("len33_no_write", wr_count - wr0, 64'd0);

        // Length 32 -> full memory
        for (int i = 0; i < 32; i++) prog[i] = $urandom();
        pulse_start();
        wr0 = wr_count;
        send_frame(32, 1'b0, 8'h00, 1'b0);
        check_done("len32");
        chk("len32_wr_count", wr_count - wr0, 64'd32);

        // Gaps between bytes plus a spurious start during DATA
        prog[0] = 32'h00500093;
        prog[1] = 32'h00108113;
        pulse_start();
        wr0 = wr_count;
        send_frame(2, 1'b1, 8'h00, 1'b1);
        check_done("gaps");
        chk("gaps_wr_count", wr_count - wr0, 64'd2);

        // Reset after 6 data bytes
        prog[0] = 32'hDEADBEEF;
        prog[1] = 32'h12345678;
        pulse_start();
        send_byte(8'h02, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back({5'd0, prog[0]});
            send_byte(prog[0][8*k +: 8], 1'b0);
        end
        send_byte(prog[1][7:0], 1'b0);
        send_byte(prog[1][15:8], 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        tick();
        chk("midreset_q_empty", exp_q.size(), 64'd0);
        rst_n = 1'b1;
        tick();
        check_reset_vals("midreset_release");

        // Fresh load after reset starts at address 0
        prog[0] = 32'hA5A55A5A;
        prog[1] = 32'h0F0F_F0F0;
        prog[2] = 32'h13579BDF;
        pulse_start();
        wr0 = wr_count;
        send_frame(3, 1'b0, 8'h00, 1'b0);
        check_done("postreset");
        chk("postreset_wr_count", wr_count - wr0, 64'd3);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
